score_event_arbiter: RTL
========================

# score_event_arbiter

Serializes scoring events from the four note columns (columns 2, 3, 5, 6) onto the single add1/add2/sub2 input of the ones-place score counter. Each column's hit/miss logic can emit an event on any cycle. The arbiter buffers events per column and issues them one at a time in round-robin order, with an enforced idle gap so the BCD carry/borrow chain settles between updates. It sits between the per-column score-keeping logic and the score-counter chain, in the divided game clock domain.

## Interface
Parameters:
- DEPTH, 2: entries per column FIFO (1–4).
- GAP, 1: idle cycles forced after each issued event (0–7).

Ports:
- Clock  in  1  game clock (divided clock tap); all logic on rising edge.
- Reset  in  1  synchronous, active-high; clears all state.
- Enable  in  1  when low, no events are issued; enqueueing continues.
- evt_code  in  8  2 bits per column, column i at [2i+1:2i]: 00 none, 01 add1, 10 add2, 11 sub2. A nonzero code is one event per cycle.
- add1  out  1  one-cycle pulse, +1 to score.
- add2  out  1  one-cycle pulse, +2 to score.
- sub2  out  1  one-cycle pulse, −2 to score.
- grant_col  out  2  column index of the event currently pulsed; holds its last value otherwise.
- busy  out  1  high while any FIFO is non-empty or the gap counter is nonzero.
- drop_count  out  8  saturating count of events lost to full FIFOs.

## Operation
- Per column: a DEPTH-entry FIFO of 2-bit codes, with a count register of width clog2(DEPTH+1).
- Push: a nonzero evt_code for column i is written to FIFO i.
  - If FIFO i is full and not popped this cycle, the event is dropped and drop_count increments.
  - drop_count saturates at 255.
  - If more than one column drops in the same cycle, drop_count adds the number of drops, still saturating at 255.
- Push and pop on the same FIFO in the same cycle:
  - Both take effect and the count is unchanged.
  - A full FIFO that is popped accepts the push.
- Grant state machine, states IDLE and HOLD:
  - IDLE: if Enable=1 and any FIFO is non-empty, select the first non-empty column at or after rr_ptr (wrapping 3→0). Then:
    - Pop the head of that FIFO.
    - Register its code onto exactly one of add1/add2/sub2 for the next cycle.
    - Set grant_col to the selected column and rr_ptr to (selected+1) mod 4.
    - If GAP>0, load gap_cnt=GAP and go to HOLD; otherwise stay in IDLE.
  - HOLD: decrement gap_cnt each cycle; return to IDLE when it reaches 0. No grants are made in HOLD.
  - Enable=0: no grants. gap_cnt still counts down.
- rr_ptr resets to 0.
- At most one of add1/add2/sub2 is high in any cycle.
- No event is reordered within a column.
- Reset:
  - Outputs: add1=add2=sub2=0, grant_col=0, busy=0, drop_count=0.
  - All FIFOs are emptied, rr_ptr=0, gap_cnt=0, state IDLE.
  - Reset asserted mid-HOLD or with pending events discards them all; no pulse follows the reset cycle.

## Timing
- Latency:
  - An event pushed at edge t into an empty system with Enable=1 pulses at the output from edge t+1 to edge t+2.
  - Push and arbitration do not bypass: the FIFO is written at t and read at t+1.
  - Hence first pulse at cycle t+1, visible for one cycle.
- Throughput: one event per GAP+1 cycles.
  - GAP=1: pulses at t+1, t+3, t+5, ...
  - GAP=0: back-to-back pulses.
- busy:
  - Goes high the cycle after the first push.
  - Goes low the cycle after the last FIFO empties and gap_cnt reaches 0.
- Enable deasserted while a pulse is being registered: that pulse still completes. Further grants stop from the next IDLE evaluation.

## Test plan
- Single event, GAP=1: evt_code=8'b00000010 (column 0, add2) for one cycle → add2 high exactly one cycle, 1 cycle later; grant_col=0; busy low 2 cycles after the pulse.
- Round robin, GAP=1: evt_code=8'b11100101 in one cycle (column 0 add1, column 1 add1, column 2 add2, column 3 sub2) → pulses add1, add1, add2, sub2 at cycles +1, +3, +5, +7; grant_col 0, 1, 2, 3.
- Fairness: column 0 gets add1 every cycle and column 2 gets one add2, with rr_ptr=1 → column 2 is granted before column 0's second event; no column is starved for more than 3 grants.
- Overflow, DEPTH=2, Enable=0: 5 add1 events on column 1 → drop_count=3. Then Enable=1 → exactly 2 add1 pulses.
- Saturation: 300 dropped events → drop_count=255.
- Reset mid-HOLD with 3 pending events → all outputs 0 the next cycle, no pulse afterwards, busy=0.

Source files
------------

// File: rtl/score_event_arbiter_if.sv
// Bus between the per-column score logic (master) and the event arbiter (slave).
// The arbiter's pulses and status go on to the ones-place score counter.
interface score_event_arbiter_if;
    logic       enable;
    logic [7:0] evt_code;
    logic       add1;
    logic       add2;
    logic       sub2;
    logic [1:0] grant_col;
    logic       busy;
    logic [7:0] drop_count;

    modport master (
        output enable,
        output evt_code,
        input  add1,
        input  add2,
        input  sub2,
        input  grant_col,
        input  busy,
        input  drop_count
    );

    modport slave (
        input  enable,
        input  evt_code,
        output add1,
        output add2,
        output sub2,
        output grant_col,
        output busy,
        output drop_count
    );
endinterface

// File: rtl/score_event_arbiter.sv
// Buffers score events from four note columns and issues them one at a time,
// round-robin, with an idle gap after each so the BCD carry chain can settle.
module score_event_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned GAP   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    score_event_arbiter_if.slave bus
);
    localparam int unsigned CntW    = $clog2(DEPTH + 1);
    localparam int unsigned NumCols = 4;

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e          state_q, state_d;
    logic [2:0]      gap_q, gap_d;
    logic [1:0]      rr_q, rr_d;
    logic [1:0]      grant_q, grant_d;
    logic            add1_q, add1_d;
    logic            add2_q, add2_d;
    logic            sub2_q, sub2_d;
    logic [7:0]      drop_q, drop_d;
    logic [1:0]      fifo_q  [NumCols][DEPTH];
    logic [1:0]      fifo_d  [NumCols][DEPTH];
    logic [CntW-1:0] count_q [NumCols];
    logic [CntW-1:0] count_d [NumCols];

    logic [NumCols-1:0] nonempty;
    logic               sel_valid;
    logic [1:0]         sel_col;
    logic [1:0]         scan_col;
    logic [1:0]         head;
    logic               pop;
    logic               col_pop;
    logic               col_push;
    logic               col_full;
    logic               push_ok;
    logic [CntW-1:0]    wr_pos;
    logic [2:0]         ndrop;
    logic [8:0]         drop_sum;

    always_comb begin
        nonempty = '0;
        for (int unsigned c = 0; c < NumCols; c++) begin
            nonempty[c] = count_q[c] != '0;
        end
    end

    // First non-empty column at or after rr_q, wrapping 3 -> 0.
    always_comb begin
        sel_valid = 1'b0;
        sel_col   = rr_q;
        scan_col  = rr_q;
        for (int unsigned k = 0; k < NumCols; k++) begin
            scan_col = rr_q + 2'(k);
            if (!sel_valid && nonempty[scan_col]) begin
                sel_valid = 1'b1;
                sel_col   = scan_col;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        add1_d  = 1'b0;
        add2_d  = 1'b0;
        sub2_d  = 1'b0;
        pop     = 1'b0;
        head    = fifo_q[sel_col][0];
        unique case (state_q)
            StIdle: begin
                if (bus.enable && sel_valid) begin
                    pop     = 1'b1;
                    grant_d = sel_col;
                    rr_d    = sel_col + 2'd1;
                    case (head)
                        2'b01:   add1_d = 1'b1;
                        2'b10:   add2_d = 1'b1;
                        2'b11:   sub2_d = 1'b1;
                        default: ;
                    endcase
                    if (GAP != 0) begin
                        gap_d   = 3'(GAP);
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (gap_q > 3'd1) begin
                    gap_d = gap_q - 3'd1;
                end else begin
                    gap_d   = '0;
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Shift-register FIFOs: entry 0 is the head. A full FIFO popped this cycle
    // still takes the push, landing in the slot vacated by the shift.
    always_comb begin
        ndrop    = '0;
        col_pop  = 1'b0;
        col_push = 1'b0;
        col_full = 1'b0;
        push_ok  = 1'b0;
        wr_pos   = '0;
        for (int unsigned c = 0; c < NumCols; c++) begin
            fifo_d[c]  = fifo_q[c];
            col_pop    = pop && (sel_col == 2'(c));
            col_push   = bus.evt_code[2*c +: 2] != 2'b00;
            col_full   = count_q[c] == CntW'(DEPTH);
            push_ok    = col_push && (!col_full || col_pop);
            wr_pos     = col_pop ? count_q[c] - CntW'(1) : count_q[c];
            if (col_pop) begin
                for (int unsigned j = 0; j + 1 < DEPTH; j++) begin
                    fifo_d[c][j] = fifo_q[c][j+1];
                end
            end
            if (push_ok) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (wr_pos == CntW'(j)) begin
                        fifo_d[c][j] = bus.evt_code[2*c +: 2];
                    end
                end
            end else if (col_push) begin
                ndrop = ndrop + 3'd1;
            end
            count_d[c] = count_q[c] + CntW'(push_ok) - CntW'(col_pop);
        end
        drop_sum = {1'b0, drop_q} + {6'b0, ndrop};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gap_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            add1_q  <= 1'b0;
            add2_q  <= 1'b0;
            sub2_q  <= 1'b0;
            drop_q  <= '0;
            for (int unsigned c = 0; c < NumCols; c++) begin
                count_q[c] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    fifo_q[c][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            add1_q  <= add1_d;
            add2_q  <= add2_d;
            sub2_q  <= sub2_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

    assign bus.add1       = add1_q;
    assign bus.add2       = add2_q;
    assign bus.sub2       = sub2_q;
    assign bus.grant_col  = grant_q;
    assign bus.drop_count = drop_q;
    assign bus.busy       = (|nonempty) || (gap_q != '0);

endmodule
